// File: rtl/axis_frame_gen.sv
// axis_frame_gen: AXI-Stream frame transmitter.
// Sends runs of programmable frames with a byte-ramp payload on a master port and honours
// tready backpressure. A run is started with `start` while idle. All cfg_* inputs are
// latched at that point, so later changes have no effect on the run in progress.
//
// Optional feature macro: AXIS_FRAME_GEN_BAD_FRAME_EN
//   When defined, every cfg_bad_interval-th frame has tuser = USER_BAD_FRAME_VALUE on its
//   tlast beat. When undefined, tuser is constant 0 and cfg_bad_interval is ignored.
//
// Ports:
//   clk, rst            clock; synchronous active-high reset
//   start, stop         run start pulse (idle only); stop pulse (sticky, never truncates a frame)
//   cfg_frame_len       frame length in bytes (0 = start ignored)
//   cfg_frame_count     frames per run (0 = continuous until stop)
//   cfg_gap             tvalid-low cycles between frames
//   cfg_seed            payload seed byte
//   cfg_id, cfg_dest    constant tid/tdest for the run
//   cfg_bad_interval    bad-frame interval (0 = none)
//   m_axis_*            AXI-Stream master (tdata/tkeep/tvalid/tready/tlast/tid/tdest/tuser)
//   busy, done          run active; 1-cycle pulse on return to idle
//   frames_sent         tlast handshakes this run
//
// state   | meaning
// IDLE    | no run; waiting for start
// SEND    | a beat is presented on the master port
// GAP     | inter-frame idle cycles; gap_cnt_q counts down to the next frame
module axis_frame_gen #(
  parameter int DATA_WIDTH = 8,
  parameter int KEEP_WIDTH = DATA_WIDTH / 8,
  parameter int ID_WIDTH = 8,
  parameter int DEST_WIDTH = 8,
  parameter int USER_WIDTH = 1,
  parameter int LEN_WIDTH = 16,
  parameter logic [USER_WIDTH-1:0] USER_BAD_FRAME_VALUE = USER_WIDTH'(1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  stop,
  input  logic [LEN_WIDTH-1:0]  cfg_frame_len,
  input  logic [15:0]           cfg_frame_count,
  input  logic [7:0]            cfg_gap,
  input  logic [7:0]            cfg_seed,
  input  logic [ID_WIDTH-1:0]   cfg_id,
  input  logic [DEST_WIDTH-1:0] cfg_dest,
  input  logic [7:0]            cfg_bad_interval,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic [KEEP_WIDTH-1:0] m_axis_tkeep,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  m_axis_tlast,
  output logic [ID_WIDTH-1:0]   m_axis_tid,
  output logic [DEST_WIDTH-1:0] m_axis_tdest,
  output logic [USER_WIDTH-1:0] m_axis_tuser,
  output logic                  busy,
  output logic                  done,
  output logic [31:0]           frames_sent
);

  typedef enum logic [1:0] {ST_IDLE, ST_SEND, ST_GAP} state_t;

  state_t                state_q, state_d;
  logic [LEN_WIDTH-1:0]  len_q, len_d;
  logic [15:0]           count_q, count_d;
  logic [7:0]            gap_q, gap_d;
  logic [ID_WIDTH-1:0]   id_q, id_d;
  logic [DEST_WIDTH-1:0] dest_q, dest_d;
  // left_q: bytes still to send in the current frame, counting the beat on the port
  logic [LEN_WIDTH-1:0]  left_q, left_d;
  // base_q: payload byte value of lane 0 of the current beat
  logic [7:0]            base_q, base_d;
  // frame_base_q: seed + frame index, i.e. lane-0 byte of the current frame's first beat
  logic [7:0]            frame_base_q, frame_base_d;
  logic [7:0]            gap_cnt_q, gap_cnt_d;
  logic                  stop_pend_q, stop_pend_d;
  logic [31:0]           sent_q, sent_d;
  logic [DATA_WIDTH-1:0] tdata_q, tdata_d;
  logic [KEEP_WIDTH-1:0] tkeep_q, tkeep_d;
  logic                  tvalid_q, tvalid_d;
  logic                  tlast_q, tlast_d;
  logic [USER_WIDTH-1:0] tuser_q, tuser_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;

  // Beat builder inputs/outputs: describe the beat to load onto the port
  logic                  load, next_frame, finish, to_gap;
  logic [LEN_WIDTH-1:0]  ld_left;
  logic [7:0]            ld_base;
  logic [DATA_WIDTH-1:0] ld_data;
  logic [KEEP_WIDTH-1:0] ld_keep;
  logic                  ld_last;

`ifdef AXIS_FRAME_GEN_BAD_FRAME_EN
  // bad_cnt_q counts down frames to the next bad one; value 1 marks the current frame bad
  logic [7:0] bad_int_q, bad_int_d;
  logic [7:0] bad_cnt_q, bad_cnt_d;
  logic [7:0] ld_cnt;
`else
  logic unused_bad_interval;
  assign unused_bad_interval = ^cfg_bad_interval;
`endif

  always_comb begin
    state_d      = state_q;
    len_d        = len_q;
    count_d      = count_q;
    gap_d        = gap_q;
    id_d         = id_q;
    dest_d       = dest_q;
    left_d       = left_q;
    base_d       = base_q;
    frame_base_d = frame_base_q;
    gap_cnt_d    = gap_cnt_q;
    sent_d       = sent_q;
    busy_d       = busy_q;
    done_d       = 1'b0;
    tdata_d      = tdata_q;
    tkeep_d      = tkeep_q;
    tvalid_d     = tvalid_q;
    tlast_d      = tlast_q;
    tuser_d      = tuser_q;
    stop_pend_d  = stop_pend_q;
    load         = 1'b0;
    next_frame   = 1'b0;
    finish       = 1'b0;
    to_gap       = 1'b0;
    ld_left      = left_q;
    ld_base      = base_q;
    ld_data      = '0;
    ld_keep      = '0;
    ld_last      = 1'b0;
`ifdef AXIS_FRAME_GEN_BAD_FRAME_EN
    bad_int_d    = bad_int_q;
    bad_cnt_d    = bad_cnt_q;
    ld_cnt       = bad_cnt_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (start && (cfg_frame_len != '0)) begin
          len_d        = cfg_frame_len;
          count_d      = cfg_frame_count;
          gap_d        = cfg_gap;
          id_d         = cfg_id;
          dest_d       = cfg_dest;
          frame_base_d = cfg_seed;
          sent_d       = 32'd0;
          busy_d       = 1'b1;
          ld_left      = cfg_frame_len;
          ld_base      = cfg_seed;
          load         = 1'b1;
          state_d      = ST_SEND;
`ifdef AXIS_FRAME_GEN_BAD_FRAME_EN
          bad_int_d    = cfg_bad_interval;
          ld_cnt       = cfg_bad_interval;
`endif
        end
      end
      ST_SEND: begin
        if (tvalid_q && m_axis_tready) begin
          if (!tlast_q) begin
            ld_left = left_q - LEN_WIDTH'(KEEP_WIDTH);
            ld_base = base_q + 8'(KEEP_WIDTH);
            load    = 1'b1;
          end else begin
            sent_d = sent_q + 32'd1;
            if (((count_q != 16'd0) && (sent_d == {16'd0, count_q})) || stop_pend_q || stop)
              finish = 1'b1;
            else if (gap_q == 8'd0)
              next_frame = 1'b1;
            else begin
              to_gap    = 1'b1;
              gap_cnt_d = gap_q;
              state_d   = ST_GAP;
            end
          end
        end
      end
      ST_GAP: begin
        if (stop_pend_q || stop)
          finish = 1'b1;
        else if (gap_cnt_q == 8'd1)
          next_frame = 1'b1;
        else
          gap_cnt_d = gap_cnt_q - 8'd1;
      end
      default: state_d = ST_IDLE;
    endcase

    if (next_frame) begin
      frame_base_d = frame_base_q + 8'd1;
      ld_left      = len_q;
      ld_base      = frame_base_q + 8'd1;
      load         = 1'b1;
      state_d      = ST_SEND;
`ifdef AXIS_FRAME_GEN_BAD_FRAME_EN
      if (bad_int_q == 8'd0)
        ld_cnt = 8'd0;
      else if (bad_cnt_q == 8'd1)
        ld_cnt = bad_int_q;
      else
        ld_cnt = bad_cnt_q - 8'd1;
`endif
    end

    // Lanes at or beyond the remaining byte count are disabled and driven to zero
    for (int i = 0; i < KEEP_WIDTH; i++) begin
      if (LEN_WIDTH'(i) < ld_left) begin
        ld_keep[i]         = 1'b1;
        ld_data[i*8 +: 8]  = ld_base + 8'(i);
      end
    end
    ld_last = (ld_left <= LEN_WIDTH'(KEEP_WIDTH));

    if (load) begin
      left_d   = ld_left;
      base_d   = ld_base;
      tvalid_d = 1'b1;
      tdata_d  = ld_data;
      tkeep_d  = ld_keep;
      tlast_d  = ld_last;
`ifdef AXIS_FRAME_GEN_BAD_FRAME_EN
      bad_cnt_d = ld_cnt;
      tuser_d   = (ld_last && (ld_cnt == 8'd1)) ? USER_BAD_FRAME_VALUE : '0;
`else
      tuser_d   = '0;
`endif
    end

    if (finish) begin
      state_d = ST_IDLE;
      busy_d  = 1'b0;
      done_d  = 1'b1;
    end

    if (finish || to_gap) begin
      tvalid_d = 1'b0;
      tdata_d  = '0;
      tkeep_d  = '0;
      tlast_d  = 1'b0;
      tuser_d  = '0;
    end

    // A stop seen while a run is active is held until the run returns to idle
    if ((state_q == ST_IDLE) || (state_d == ST_IDLE))
      stop_pend_d = 1'b0;
    else
      stop_pend_d = stop_pend_q || stop;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      len_q        <= '0;
      count_q      <= '0;
      gap_q        <= '0;
      id_q         <= '0;
      dest_q       <= '0;
      left_q       <= '0;
      base_q       <= '0;
      frame_base_q <= '0;
      gap_cnt_q    <= '0;
      stop_pend_q  <= 1'b0;
      sent_q       <= '0;
      tdata_q      <= '0;
      tkeep_q      <= '0;
      tvalid_q     <= 1'b0;
      tlast_q      <= 1'b0;
      tuser_q      <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
`ifdef AXIS_FRAME_GEN_BAD_FRAME_EN
      bad_int_q    <= '0;
      bad_cnt_q    <= '0;
`endif
    end else begin
      state_q      <= state_d;
      len_q        <= len_d;
      count_q      <= count_d;
      gap_q        <= gap_d;
      id_q         <= id_d;
      dest_q       <= dest_d;
      left_q       <= left_d;
      base_q       <= base_d;
      frame_base_q <= frame_base_d;
      gap_cnt_q    <= gap_cnt_d;
      stop_pend_q  <= stop_pend_d;
      sent_q       <= sent_d;
      tdata_q      <= tdata_d;
      tkeep_q      <= tkeep_d;
      tvalid_q     <= tvalid_d;
      tlast_q      <= tlast_d;
      tuser_q      <= tuser_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
`ifdef AXIS_FRAME_GEN_BAD_FRAME_EN
      bad_int_q    <= bad_int_d;
      bad_cnt_q    <= bad_cnt_d;
`endif
    end
  end

  assign m_axis_tdata  = tdata_q;
  assign m_axis_tkeep  = tkeep_q;
  assign m_axis_tvalid = tvalid_q;
  assign m_axis_tlast  = tlast_q;
  assign m_axis_tid    = id_q;
  assign m_axis_tdest  = dest_q;
  assign m_axis_tuser  = tuser_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign frames_sent   = sent_q;

endmodule

// File: tb/tb_axis_frame_gen.sv
// Bench for axis_frame_gen with a 32-bit data path (4 byte lanes).
// A reference model derives every beat from the run configuration plus the frame and beat
// index. A compare process checks the port against that model on each negedge.
module tb_axis_frame_gen;
  localparam int DW = 32;
  localparam int KW = 4;

  logic          clk = 1'b0;
  logic          rst, start, stop;
  logic [15:0]   cfg_frame_len, cfg_frame_count;
  logic [7:0]    cfg_gap, cfg_seed, cfg_id, cfg_dest, cfg_bad_interval;
  logic [DW-1:0] m_axis_tdata;
  logic [KW-1:0] m_axis_tkeep;
  logic          m_axis_tvalid, m_axis_tready, m_axis_tlast;
  logic [7:0]    m_axis_tid, m_axis_tdest;
  logic [0:0]    m_axis_tuser;
  logic          busy, done;
  logic [31:0]   frames_sent;

  always #5 clk = ~clk;

  axis_frame_gen #(.DATA_WIDTH(DW), .KEEP_WIDTH(KW), .ID_WIDTH(8), .DEST_WIDTH(8),
                   .USER_WIDTH(1), .LEN_WIDTH(16)) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop),
    .cfg_frame_len(cfg_frame_len), .cfg_frame_count(cfg_frame_count), .cfg_gap(cfg_gap),
    .cfg_seed(cfg_seed), .cfg_id(cfg_id), .cfg_dest(cfg_dest),
    .cfg_bad_interval(cfg_bad_interval),
    .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep), .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready), .m_axis_tlast(m_axis_tlast), .m_axis_tid(m_axis_tid),
    .m_axis_tdest(m_axis_tdest), .m_axis_tuser(m_axis_tuser),
    .busy(busy), .done(done), .frames_sent(frames_sent)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic timeout_fail(input string name);
    checks++;
    failures++;
    $display("FAIL %s actual=timeout required=event", name);
  endtask

  // Model state: configuration of the run in progress and position in the stream
  bit          m_active = 0;
  int          m_len, m_count, m_gap, m_seed, m_id, m_dest, m_bad;
  int          mf, mb, low_cnt;
  bit          gap_pending, stall_prev, last_xfer_last;
  logic [38:0] saved;
  logic [15:0] bad_mask;
  logic [31:0] beat_log[$];
  logic [3:0]  keep_log[$];
  int          gap_log[$];

  logic [31:0] e_data;
  logic [3:0]  e_keep;
  bit          e_last, e_user;
  int          k;

  initial begin
    forever begin
      @(negedge clk);
      if (!m_active) begin
        stall_prev = 0;
      end else begin
        if (stall_prev)
          chk("stall_hold", {m_axis_tvalid, m_axis_tlast, m_axis_tuser, m_axis_tkeep, m_axis_tdata}, saved);
        if (m_axis_tvalid) begin
          if (gap_pending) begin
            chk("gap_len", low_cnt, m_gap);
            gap_log.push_back(low_cnt);
            gap_pending = 0;
          end
          e_data = '0;
          e_keep = '0;
          for (int lane = 0; lane < KW; lane++) begin
            k = mb * KW + lane;
            if (k < m_len) begin
              e_data[lane*8 +: 8] = 8'((m_seed + mf + k) % 256);
              e_keep[lane] = 1'b1;
            end
          end
          e_last = (mb == (m_len + KW - 1) / KW - 1);
`ifdef AXIS_FRAME_GEN_BAD_FRAME_EN
          e_user = e_last && (m_bad != 0) && (((mf + 1) % m_bad) == 0);
`else
          e_user = 0;
`endif
          chk("tdata", m_axis_tdata, e_data);
          chk("tkeep", m_axis_tkeep, e_keep);
          chk("tlast", m_axis_tlast, e_last);
          chk("tuser", m_axis_tuser, e_user);
          chk("tid", m_axis_tid, m_id);
          chk("tdest", m_axis_tdest, m_dest);
          if (m_axis_tready) begin
            stall_prev = 0;
            beat_log.push_back(m_axis_tdata);
            keep_log.push_back(m_axis_tkeep);
            last_xfer_last = m_axis_tlast;
            if (e_last) begin
              if (mf < 16) bad_mask[mf] = m_axis_tuser[0];
              mf++;
              mb = 0;
              gap_pending = 1;
              low_cnt = 0;
            end else begin
              mb++;
            end
          end else begin
            stall_prev = 1;
            saved = {m_axis_tvalid, m_axis_tlast, m_axis_tuser, m_axis_tkeep, m_axis_tdata};
          end
        end else begin
          stall_prev = 0;
          if (gap_pending) low_cnt++;
        end
      end
    end
  end

  task automatic start_run(input int len, input int count, input int gap, input int seed,
                           input int id, input int dest, input int bad);
    @(posedge clk); #1;
    cfg_frame_len = 16'(len); cfg_frame_count = 16'(count); cfg_gap = 8'(gap);
    cfg_seed = 8'(seed); cfg_id = 8'(id); cfg_dest = 8'(dest); cfg_bad_interval = 8'(bad);
    start = 1;
    m_len = len; m_count = count; m_gap = gap; m_seed = seed; m_id = id; m_dest = dest;
    m_bad = bad; mf = 0; mb = 0; low_cnt = 0; gap_pending = 0; stall_prev = 0;
    last_xfer_last = 0; bad_mask = '0;
    beat_log.delete(); keep_log.delete(); gap_log.delete();
    m_active = 1;
    @(posedge clk); #1;
    start = 0;
    // Disturb the live configuration; the run must keep using its latched copy
    cfg_frame_len = 16'd7; cfg_frame_count = 16'd1; cfg_gap = 8'd9; cfg_seed = 8'hAA;
    cfg_id = ~8'(id); cfg_dest = ~8'(dest); cfg_bad_interval = 8'd3;
  endtask

  // mode 0: tready held 1; 1: toggles every cycle; 2: random
  task automatic run_until_done(input int mode, input int budget, output int cycles);
    bit seen;
    seen = 0;
    cycles = 0;
    while (!seen && cycles < budget) begin
      @(negedge clk);
      if (done) seen = 1;
      else begin
        @(posedge clk); #1;
        if (mode == 1) m_axis_tready = ~m_axis_tready;
        else if (mode == 2) m_axis_tready = 1'($urandom_range(0, 1));
        cycles++;
      end
    end
    if (!seen) timeout_fail("done_wait");
    m_axis_tready = 1;
  endtask

  task automatic wait_pos(input int f, input int b, input int budget);
    int n;
    n = 0;
    while (!(mf == f && mb == b) && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (!(mf == f && mb == b)) timeout_fail("pos_wait");
  endtask

  int cyc;

  initial begin
    rst = 1; start = 0; stop = 0; m_axis_tready = 1;
    cfg_frame_len = 0; cfg_frame_count = 0; cfg_gap = 0; cfg_seed = 0;
    cfg_id = 0; cfg_dest = 0; cfg_bad_interval = 0;
    repeat (3) @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    chk("rst_tvalid", m_axis_tvalid, 0);
    chk("rst_tlast", m_axis_tlast, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_frames_sent", frames_sent, 0);
    chk("rst_tdata", m_axis_tdata, 0);
    chk("rst_tkeep", m_axis_tkeep, 0);
    chk("rst_tuser", m_axis_tuser, 0);

    // len = 0 leaves the generator idle
    @(posedge clk); #1 cfg_frame_len = 0; cfg_frame_count = 1; start = 1;
    @(posedge clk); #1 start = 0;
    @(negedge clk);
    chk("len0_busy", busy, 0);
    chk("len0_tvalid", m_axis_tvalid, 0);

    // Two 10-byte frames back to back, no backpressure
    start_run(10, 2, 0, 8'h10, 8'h5A, 8'hC3, 0);
    @(negedge clk);
    chk("a_busy_n1", busy, 1);
    chk("a_valid_n1", m_axis_tvalid, 1);
    run_until_done(0, 200, cyc);
    chk("a_frames_sent", frames_sent, 2);
    chk("a_busy_at_done", busy, 0);
    chk("a_beats", beat_log.size(), 6);
    if (beat_log.size() == 6) begin
      chk("a_beat0", beat_log[0], 32'h13121110);
      chk("a_beat1", beat_log[1], 32'h17161514);
      chk("a_beat2", beat_log[2], 32'h00001918);
      chk("a_beat3", beat_log[3], 32'h14131211);
      chk("a_keep0", keep_log[0], 4'hF);
      chk("a_keep2", keep_log[2], 4'h3);
    end
    chk("a_no_bubble", (gap_log.size() == 1) ? gap_log[0] : -1, 0);

    // Same run with tready toggling each cycle
    start_run(10, 2, 0, 8'h10, 8'h5A, 8'hC3, 0);
    run_until_done(1, 300, cyc);
    chk("b_frames_sent", frames_sent, 2);
    chk("b_beats", beat_log.size(), 6);
    if (beat_log.size() == 6) begin
      chk("b_beat1", beat_log[1], 32'h17161514);
      chk("b_beat3", beat_log[3], 32'h14131211);
    end

    // Single-beat frames with a 5-cycle gap, random backpressure, start while busy ignored
    start_run(4, 3, 5, 8'h80, 8'h01, 8'h02, 0);
    repeat (3) @(posedge clk);
    #1 start = 1;
    @(posedge clk); #1 start = 0;
    run_until_done(2, 400, cyc);
    chk("c_frames_sent", frames_sent, 3);
    chk("c_gap_count", gap_log.size(), 2);
    if (gap_log.size() == 2) begin
      chk("c_gap0", gap_log[0], 5);
      chk("c_gap1", gap_log[1], 5);
    end
    if (beat_log.size() == 3) chk("c_frame2", beat_log[2], 32'h85848382);
    else timeout_fail("c_frame2_missing");

    // Continuous run stopped during frame 3
    start_run(10, 0, 2, 8'h33, 8'h11, 8'h22, 0);
    wait_pos(3, 1, 400);
    @(posedge clk); #1 stop = 1;
    @(posedge clk); #1 stop = 0;
    run_until_done(0, 100, cyc);
    chk("d_frames_sent", frames_sent, 4);
    chk("d_frames_seen", mf, 4);
    chk("d_ended_on_tlast", last_xfer_last, 1);

    // Stop during a long gap ends the run on the next cycle
    start_run(4, 0, 20, 8'h00, 8'h11, 8'h22, 0);
    wait_pos(1, 0, 100);
    @(posedge clk); #1 stop = 1;
    @(posedge clk); #1 stop = 0;
    run_until_done(0, 50, cyc);
    chk("d2_latency", cyc, 0);
    chk("d2_frames_sent", frames_sent, 1);

    // Reset while beat 2 of frame 0 is on the port
    start_run(10, 2, 0, 8'h10, 8'h5A, 8'hC3, 0);
    wait_pos(0, 2, 100);
    @(posedge clk); #1;
    m_active = 0; m_axis_tready = 0; rst = 1;
    @(posedge clk); #1 rst = 0; m_axis_tready = 1;
    @(negedge clk);
    chk("e_tvalid", m_axis_tvalid, 0);
    chk("e_busy", busy, 0);
    chk("e_done", done, 0);
    chk("e_frames_sent", frames_sent, 0);
    start_run(10, 2, 0, 8'h10, 8'h5A, 8'hC3, 0);
    run_until_done(0, 200, cyc);
    chk("e_rerun_frames", frames_sent, 2);
    if (beat_log.size() > 0) chk("e_rerun_beat0", beat_log[0], 32'h13121110);
    else timeout_fail("e_rerun_missing");

    // Bad-frame interval 2 over 4 frames
    start_run(4, 4, 1, 8'h00, 8'h44, 8'h55, 2);
    run_until_done(0, 200, cyc);
    chk("f_frames_sent", frames_sent, 4);
`ifdef AXIS_FRAME_GEN_BAD_FRAME_EN
    chk("f_bad_mask", bad_mask[3:0], 4'b1010);
`else
    chk("f_bad_mask", bad_mask[3:0], 4'b0000);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "bench timeout");
  end

endmodule
